// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM speaker/microphone blocks.
// Holds integrator sizing, the modulator feedback magnitude and LFSR dither constants.
package pdm_pkg;

    localparam int SAMPLE_DEPTH_DEF = 16;
    localparam int GUARD_BITS_DEF   = 4;

    // Galois LFSR for taps 16,14,13,11, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int integ_width(input int sample_depth, input int guard_bits);
        return sample_depth + guard_bits;
    endfunction

    // Modulator feedback magnitude F = 2^(SAMPLE_DEPTH-1).
    function automatic longint fb_mag(input int sample_depth);
        return longint'(1) <<< (sample_depth - 1);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/pdm_speaker_if.sv
// Sample stream handshake between an audio source (master) and the PDM speaker (slave).
interface pdm_speaker_if
    import pdm_pkg::*;
#(
    parameter int SAMPLE_DEPTH = SAMPLE_DEPTH_DEF
);

    logic signed [SAMPLE_DEPTH-1:0] audio_in;
    logic                           audio_valid;
    logic                           audio_ready;

    modport master (output audio_in, output audio_valid, input audio_ready);
    modport slave  (input audio_in, input audio_valid, output audio_ready);

endinterface

// File: rtl/pdm_clk_gen.sv
// PDM bit clock divider: pdm_clk = clk/CLK_DIV at 50% duty, bit_stb marks each falling edge.
// Shared with the microphone front end, which runs the same bit clock.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pdm_clk,
    output logic bit_stb
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    always_comb begin
        div_nxt = (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pdm_clk <= (div_nxt >= HALF);
        end
    end

    // High in the cycle whose closing edge wraps the divider, so consumers update as pdm_clk falls.
    assign bit_stb = (div_cnt == LAST);

endmodule

// File: rtl/pdm_speaker.sv
// PCM-to-PDM transmitter: one-entry sample buffer feeding a saturating second-order sigma-delta.
// Optional LFSR dither on the modulator input is enabled by defining PDM_SPEAKER_DITHER_EN.
module pdm_speaker
    import pdm_pkg::*;
#(
    parameter int SAMPLE_DEPTH = SAMPLE_DEPTH_DEF,
    parameter int CLK_DIV      = 4,
    parameter int OVERSAMPLE   = 64,
    parameter int GUARD_BITS   = GUARD_BITS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pdm_speaker_if.slave  audio,
    output logic          pdm_clk,
    output logic          pdm_out,
    output logic          underrun
);

    localparam int W  = integ_width(SAMPLE_DEPTH, GUARD_BITS);
    localparam int EW = W + 2;
    localparam int BW = $clog2(OVERSAMPLE);

    localparam logic signed [EW-1:0] FB    = EW'(fb_mag(SAMPLE_DEPTH));
    localparam logic signed [EW-1:0] I_MAX = EW'((longint'(1) <<< (W - 1)) - 1);
    localparam logic signed [EW-1:0] I_MIN = EW'(-(longint'(1) <<< (W - 1)));
    localparam logic [BW-1:0]        LAST_BIT = BW'(OVERSAMPLE - 1);

    logic                           bit_stb;
    logic                           boundary;
    logic                           xfer;
    logic                           pending_full;
    logic                           pending_full_nxt;
    logic [BW-1:0]                  bit_cnt;
    logic signed [SAMPLE_DEPTH-1:0] current;
    logic signed [SAMPLE_DEPTH-1:0] pending;
    logic signed [W-1:0]            i1;
    logic signed [W-1:0]            i2;
    logic signed [W-1:0]            i1_nxt;
    logic signed [W-1:0]            i2_nxt;
    logic signed [EW-1:0]           fb;
    logic signed [EW-1:0]           mod_in;

    function automatic logic signed [W-1:0] sat(input logic signed [EW-1:0] v);
        if (v > I_MAX) return I_MAX[W-1:0];
        if (v < I_MIN) return I_MIN[W-1:0];
        return v[W-1:0];
    endfunction

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .pdm_clk (pdm_clk),
        .bit_stb (bit_stb)
    );

    assign boundary         = bit_stb && (bit_cnt == LAST_BIT);
    assign xfer             = audio.audio_valid && audio.audio_ready;
    assign pending_full_nxt = xfer || (pending_full && !boundary);
    // An empty buffer at a boundary flags underrun even if a sample is arriving that same cycle.
    assign underrun         = boundary && !pending_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt           <= '0;
            current           <= '0;
            pending           <= '0;
            pending_full      <= 1'b0;
            audio.audio_ready <= 1'b0;
        end else begin
            if (bit_stb) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (boundary && pending_full) begin
                current <= pending;
            end
            if (xfer) begin
                pending <= audio.audio_in;
            end else if (boundary && pending_full) begin
                pending <= '0;
            end
            pending_full      <= pending_full_nxt;
            audio.audio_ready <= !pending_full_nxt;
        end
    end

`ifdef PDM_SPEAKER_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (bit_stb) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign mod_in = EW'(current) + (lfsr[0] ? EW'(1) : EW'(-1));
`else
    assign mod_in = EW'(current);
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        fb     = pdm_out ? FB : -FB;
        i1_nxt = sat(EW'(i1) + mod_in - fb);
        i2_nxt = sat(EW'(i2) + EW'(i1_nxt) - fb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            pdm_out <= 1'b0;
        end else if (bit_stb) begin
            i1      <= i1_nxt;
            i2      <= i2_nxt;
            pdm_out <= !i2_nxt[W-1];
        end
    end

endmodule

// File: tb/tb_pdm_speaker.sv
// Self-checking bench for pdm_speaker: time-based behavioural model compared on every clock,
// plus literal density, latency and handshake expectations.
module tb_pdm_speaker;

    localparam int     SD          = 16;
    localparam int     CD          = 4;
    localparam int     OS          = 64;
    localparam int     GB          = 4;
    localparam int     SAMPLE_CLKS = CD * OS;
    localparam longint F           = 64'sd32768;
    localparam longint IMAX        = (longint'(1) <<< (SD + GB - 1)) - 1;
    localparam longint IMIN        = -(longint'(1) <<< (SD + GB - 1));

    typedef enum {M_IDLE, M_CONST, M_INC, M_RAND} mode_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pdm_clk;
    logic pdm_out;
    logic underrun;

    pdm_speaker_if #(.SAMPLE_DEPTH(SD)) audio ();

    pdm_speaker #(
        .SAMPLE_DEPTH (SD),
        .CLK_DIV      (CD),
        .OVERSAMPLE   (OS),
        .GUARD_BITS   (GB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .audio    (audio),
        .pdm_clk  (pdm_clk),
        .pdm_out  (pdm_out),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release, sample buffer, integrators.
    longint m_t;
    longint m_cur;
    longint m_pend;
    bit     m_pfull;
    bit     m_ready;
    longint m_i1;
    longint m_i2;
    bit     m_out;
    int     m_xfers = 0;
    logic [15:0] m_lfsr;

    bit     chk_en    = 1'b0;
    bit     rec_first = 1'b0;
    logic   prev_out  = 1'b0;
    logic [7:0] first_bits = '0;
    int     bits_cnt  = 0;
    int     ones_cnt  = 0;
    int     und_cnt   = 0;
    int     off_edge  = 0;
    longint inc_val   = -16000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_cur = 0; m_pend = 0; m_pfull = 0; m_ready = 0;
        m_i1 = 0; m_i2 = 0; m_out = 0; m_lfsr = 16'hACE1;
    endtask

    // One clock edge: a PDM bit every CD edges, a sample boundary every SAMPLE_CLKS edges.
    task automatic model_edge(input bit v, input longint d);
        longint x;
        longint fbv;
        m_t++;
        if (m_t % CD == 0) begin
            x = m_cur;
`ifdef PDM_SPEAKER_DITHER_EN
            x = x + (m_lfsr[0] ? 1 : -1);
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
            fbv   = m_out ? F : -F;
            m_i1  = clamp(m_i1 + x - fbv);
            m_i2  = clamp(m_i2 + m_i1 - fbv);
            m_out = (m_i2 >= 0);
        end
        if (m_t % SAMPLE_CLKS == 0 && m_pfull) begin
            m_cur   = m_pend;
            m_pfull = 0;
        end
        if (v && m_ready) begin
            m_pend  = d;
            m_pfull = 1;
            m_xfers++;
        end
        m_ready = !m_pfull;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pdm_clk", pdm_clk, 64'((m_t % CD) >= CD / 2));
            check("pdm_out", pdm_out, 64'(m_out));
            check("audio_ready", audio.audio_ready, 64'(m_ready));
            check("underrun", underrun, 64'(((m_t + 1) % SAMPLE_CLKS == 0) && !m_pfull));
            if (pdm_out !== prev_out && (m_t % CD) != 0) off_edge++;
            prev_out = pdm_out;
        end
    end

    task automatic cycle(input bit v, input longint d);
        audio.audio_valid = v;
        audio.audio_in    = 16'(d);
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        if (m_t % CD == 0) begin
            bits_cnt++;
            ones_cnt += int'(pdm_out);
            if (rec_first && m_t <= 8 * CD) first_bits = {first_bits[6:0], pdm_out};
        end
        und_cnt += int'(underrun);
    endtask

    task automatic run(input mode_e m, input int n, input longint val);
        for (int c = 0; c < n; c++) begin
            bit                 v;
            longint             d;
            logic signed [15:0] r;
            int                 x0;
            r = 16'($urandom);
            case (m)
                M_IDLE:  begin v = 0; d = 0; end
                M_CONST: begin v = 1; d = val; end
                M_INC:   begin v = 1; d = inc_val; end
                default: begin v = ($urandom_range(0, 7) == 0); d = r; end
            endcase
            x0 = m_xfers;
            cycle(v, d);
            if (m == M_INC && m_xfers != x0) inc_val += 2731;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  o0;
        int  b0;
        int  u0;
        int  x0;
        bit  found;
        logic signed [15:0] r;

        audio.audio_valid = 1'b0;
        audio.audio_in    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_ready", audio.audio_ready, 0);
        check("rst_underrun", underrun, 0);

        rst = 1'b0;
        model_reset();
        rec_first = 1'b1;
        chk_en    = 1'b1;

        // First sample: accepted at edge 2, becomes current at edge OS*CD.
        cycle(1, 0);
        check("ready_after_release", audio.audio_ready, 1);
        cycle(1, 0);
        check("ready_low_pending_full", audio.audio_ready, 0);
        run(M_CONST, SAMPLE_CLKS - 3, 0);
        check("ready_low_before_bnd", audio.audio_ready, 0);
        cycle(1, 0);
        check("ready_after_first_bnd", audio.audio_ready, 1);
        rec_first = 1'b0;
`ifndef PDM_SPEAKER_DITHER_EN
        check("first_eight_bits", first_bits, 8'hD3);
`endif

        // Zero input: ones count over 1024 bits.
        run(M_CONST, 4 * SAMPLE_CLKS, 0);
        o0 = ones_cnt; b0 = bits_cnt;
        run(M_CONST, 16 * SAMPLE_CLKS, 0);
        check("zero_bits", bits_cnt - b0, 1024);
        check_range("zero_ones", ones_cnt - o0, 510, 514);

        // Backpressure with incrementing data: one transfer per sample period.
        x0 = m_xfers;
        run(M_INC, 12 * SAMPLE_CLKS, 0);
        check("inc_xfers", m_xfers - x0, 12);

        // Full scale positive, then negative.
        run(M_CONST, 4 * SAMPLE_CLKS, 32767);
        o0 = ones_cnt;
        run(M_CONST, 16 * SAMPLE_CLKS, 32767);
        check_range("fs_pos_ones", ones_cnt - o0, 1014, 1024);
        run(M_CONST, SAMPLE_CLKS + 8 * CD, -32768);
        o0 = ones_cnt; b0 = bits_cnt;
        run(M_CONST, 7 * SAMPLE_CLKS - 8 * CD, -32768);
        check("fs_neg_bits", bits_cnt - b0, 440);
        check("fs_neg_ones", ones_cnt - o0, 0);

        // Underrun: one sample then silence; density keeps tracking 0x2000 (0.625).
        u0 = und_cnt;
        cycle(1, 8192);
        run(M_IDLE, 2 * SAMPLE_CLKS - 1, 0);
        o0 = ones_cnt;
        run(M_IDLE, 4 * SAMPLE_CLKS, 0);
        check_range("hold_ones", ones_cnt - o0, 157, 163);
        check("underrun_pulses", und_cnt - u0, 5);

        // Sample offered in the underrun cycle lands in pending for the next boundary.
        run(M_IDLE, SAMPLE_CLKS - 1, 0);
        check("underrun_at_bnd", underrun, 1);
        cycle(1, -12288);
        check("bnd_xfer_pending", audio.audio_ready, 0);
        run(M_IDLE, SAMPLE_CLKS - 1, 0);
        check("no_underrun_pending", underrun, 0);
        cycle(0, 0);
        check("ready_after_consume", audio.audio_ready, 1);
        run(M_IDLE, 2 * SAMPLE_CLKS, 0);

        // Random traffic.
        run(M_RAND, 16 * SAMPLE_CLKS, 0);

        // Asynchronous reset while pdm_clk is high and the buffer is full.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            r = 16'($urandom);
            cycle(1, r);
            found = m_pfull && (m_t % CD == 2);
        end
        check("reset_setup", found, 1);
        check("pre_reset_pdm_clk", pdm_clk, 1);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_pdm_clk", pdm_clk, 0);
        check("async_rst_pdm_out", pdm_out, 0);
        check("async_rst_ready", audio.audio_ready, 0);
        check("async_rst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        cycle(0, 0);
        check("ready_after_midrst", audio.audio_ready, 1);
        run(M_RAND, 4 * SAMPLE_CLKS, 0);

        check("off_edge_toggles", off_edge, 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
